// File: rtl/axis_vid_pkg.sv
// Shared constants for the AXI4-Stream to parallel video output path:
// default 720p timing, lock-FSM state encoding and a counter width helper.
package axis_vid_pkg;

  localparam int unsigned DefHActive = 1280;
  localparam int unsigned DefHFp     = 110;
  localparam int unsigned DefHSync   = 40;
  localparam int unsigned DefHBp     = 220;
  localparam int unsigned DefVActive = 720;
  localparam int unsigned DefVFp     = 5;
  localparam int unsigned DefVSync   = 5;
  localparam int unsigned DefVBp     = 20;

  typedef logic [1:0] vid_state_e;
  localparam vid_state_e StSearch = 2'd0;
  localparam vid_state_e StWait   = 2'd1;
  localparam vid_state_e StLocked = 2'd2;

  // Bits needed to count 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Free-running raster counters producing active, raw syncs (active-high),
// the end-of-active-line marker and the frame-start strobe.
module vid_timing_gen
  import axis_vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic line_end,
  output logic frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = clog2(HTotal);
  localparam int unsigned VW     = clog2(VTotal);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(HTotal - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(VTotal - 1)) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // vsync derives from v_cnt only, so it naturally toggles at h_cnt == 0.
  assign active      = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  assign hsync       = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                       (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync       = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                       (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign line_end    = (h_cnt_q == HW'(H_ACTIVE - 1));
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/axis_vid_out.sv
// AXI4-Stream video (tuser = SOF, tlast = EOL) to parallel video for rgb2dvi.
// Locks the stream to the local raster and falls back to SEARCH on any fault.
module axis_vid_out
  import axis_vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tuser,
  input  logic        s_axis_video_tlast,
  output logic [23:0] vid_data,
  output logic        vid_active,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err
);

  logic tg_active, tg_hsync, tg_vsync, line_end, frame_start;

  vid_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .active      (tg_active),
    .hsync       (tg_hsync),
    .vsync       (tg_vsync),
    .line_end    (line_end),
    .frame_start (frame_start)
  );

  logic unused_tdata_hi;
  assign unused_tdata_hi = ^s_axis_video_tdata[31:24];

  vid_state_e  state_q, state_d;
  logic        take_pixel;
  logic [23:0] vid_data_q, vid_data_d;
  logic        vid_active_q, vid_hsync_q, vid_vsync_q;
  logic        underflow_q, underflow_d, sync_err_q, sync_err_d;

  // Only SEARCH looks at tvalid/tuser, so the SOF beat is never swallowed there.
  always_comb begin
    case (state_q)
      StSearch: s_axis_video_tready = !(s_axis_video_tvalid && s_axis_video_tuser);
      StWait:   s_axis_video_tready = frame_start;
      StLocked: s_axis_video_tready = tg_active;
      default:  s_axis_video_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    take_pixel  = 1'b0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    case (state_q)
      StSearch: begin
        if (s_axis_video_tvalid && s_axis_video_tuser) state_d = StWait;
      end
      StWait: begin
        // A held SOF that vanished by (0,0) gives nothing to lock to; start over.
        if (frame_start) begin
          if (s_axis_video_tvalid && s_axis_video_tuser) begin
            state_d    = StLocked;
            take_pixel = 1'b1;
          end else begin
            state_d = StSearch;
          end
        end
      end
      StLocked: begin
        if (tg_active) begin
          if (!s_axis_video_tvalid) begin
            underflow_d = 1'b1;
            state_d     = StSearch;
          end else if ((s_axis_video_tuser && !frame_start) ||
                       (s_axis_video_tlast != line_end)) begin
            sync_err_d = 1'b1;
            state_d    = StSearch;
          end else begin
            take_pixel = 1'b1;
          end
        end
      end
      default: state_d = StSearch;
    endcase
  end

  assign vid_data_d = take_pixel ? s_axis_video_tdata[23:0] : 24'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSearch;
      vid_data_q   <= 24'h0;
      vid_active_q <= 1'b0;
      vid_hsync_q  <= ~HS_POL;
      vid_vsync_q  <= ~VS_POL;
      underflow_q  <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vid_data_q   <= vid_data_d;
      vid_active_q <= tg_active;
      vid_hsync_q  <= tg_hsync ? HS_POL : ~HS_POL;
      vid_vsync_q  <= tg_vsync ? VS_POL : ~VS_POL;
      underflow_q  <= underflow_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_active = vid_active_q;
  assign vid_hsync  = vid_hsync_q;
  assign vid_vsync  = vid_vsync_q;
  assign locked     = (state_q == StLocked);
  assign underflow  = underflow_q;
  assign sync_err   = sync_err_q;

endmodule
